// File: rtl/alarm_mode_ctrl_pkg.sv
// Shared types and constants for the alarm-clock mode controller.
package alarm_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    ADJ  = 2'd1,
    RING = 2'd2
  } state_t;

  localparam logic [1:0] F_THR  = 2'd0;
  localparam logic [1:0] F_TMIN = 2'd1;
  localparam logic [1:0] F_AHR  = 2'd2;
  localparam logic [1:0] F_AMIN = 2'd3;

  localparam int HR_MAX  = 23;
  localparam int MIN_MAX = 59;
  localparam int HR_W    = 5;
  localparam int MIN_W   = 6;

  // Field index to the one-hot select seen by the display/edit datapath.
  function automatic logic [3:0] fld_onehot(input logic [1:0] f);
    return 4'b0001 << f;
  endfunction

endpackage

// File: rtl/alarm_mode_ctrl_if.sv
// Button/time inputs and display/timekeeper outputs of the mode controller.
interface alarm_mode_ctrl_if;
  logic       btn_c;
  logic       btn_l;
  logic       btn_r;
  logic       btn_u;
  logic       btn_d;
  logic       tick_1hz;
  logic       alarm_en;
  logic [4:0] cur_hr;
  logic [5:0] cur_min;
  logic [5:0] cur_sec;
  logic [3:0] mode;
  logic [4:0] edit_hr;
  logic [5:0] edit_min;
  logic       time_load;
  logic [4:0] alm_hr;
  logic [5:0] alm_min;
  logic       buzz;
  logic       adj_active;

  modport master (
    output btn_c, btn_l, btn_r, btn_u, btn_d, tick_1hz, alarm_en,
    output cur_hr, cur_min, cur_sec,
    input  mode, edit_hr, edit_min, time_load, alm_hr, alm_min, buzz, adj_active
  );

  modport slave (
    input  btn_c, btn_l, btn_r, btn_u, btn_d, tick_1hz, alarm_en,
    input  cur_hr, cur_min, cur_sec,
    output mode, edit_hr, edit_min, time_load, alm_hr, alm_min, buzz, adj_active
  );
endinterface

// File: rtl/alarm_mode_ctrl_mod_adj.sv
// Wrapping increment/decrement of a field value within 0..i_max.
module mod_adj #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_val,
  input  logic [W-1:0] i_max,
  input  logic         i_up,
  input  logic         i_down,
  output logic [W-1:0] o_next
);

  localparam logic [W-1:0] ONE = W'(1);

  // Up and down together cancel; otherwise step with wrap at both ends.
  always_comb begin
    o_next = i_val;
    if (i_up && !i_down) begin
      o_next = (i_val == i_max) ? '0 : i_val + ONE;
    end else if (i_down && !i_up) begin
      o_next = (i_val == '0) ? i_max : i_val - ONE;
    end
  end

endmodule

// File: rtl/alarm_mode_ctrl.sv
// Alarm clock mode controller: time/alarm adjust sequencing, alarm match, ringing.
module alarm_mode_ctrl
  import alarm_pkg::*;
#(
  parameter int RING_SECS = 60
) (
  input logic             clk,
  input logic             rst,
  alarm_mode_ctrl_if.slave bus
);

  localparam logic [7:0]       RING_LAST = 8'(RING_SECS - 1);
  localparam logic [HR_W-1:0]  HR_LIM    = HR_W'(HR_MAX);
  localparam logic [MIN_W-1:0] MIN_LIM   = MIN_W'(MIN_MAX);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_fld, w_fld_nxt;
  logic [HR_W-1:0]  r_edit_hr, w_edit_hr_nxt;
  logic [MIN_W-1:0] r_edit_min, w_edit_min_nxt;
  logic [HR_W-1:0]  r_alm_hr, w_alm_hr_nxt;
  logic [MIN_W-1:0] r_alm_min, w_alm_min_nxt;
  logic [7:0]       r_ring_cnt, w_ring_cnt_nxt;
  logic             r_time_load, w_time_load_nxt;
  logic [3:0]       r_mode, w_mode_nxt;
  logic             r_buzz, w_buzz_nxt;
  logic             r_adj_active, w_adj_active_nxt;

  logic [HR_W-1:0]  w_hr_val, w_hr_next;
  logic [MIN_W-1:0] w_min_val, w_min_next;
  logic             w_match;

  // Time and alarm fields share one adjuster per width; fld[1] picks alarm vs time.
  assign w_hr_val  = r_fld[1] ? r_alm_hr  : r_edit_hr;
  assign w_min_val = r_fld[1] ? r_alm_min : r_edit_min;

  mod_adj #(.W(HR_W)) u_adj_hr (
    .i_val  (w_hr_val),
    .i_max  (HR_LIM),
    .i_up   (bus.btn_u),
    .i_down (bus.btn_d),
    .o_next (w_hr_next)
  );

  mod_adj #(.W(MIN_W)) u_adj_min (
    .i_val  (w_min_val),
    .i_max  (MIN_LIM),
    .i_up   (bus.btn_u),
    .i_down (bus.btn_d),
    .o_next (w_min_next)
  );

  assign w_match = bus.alarm_en && bus.tick_1hz && (bus.cur_sec == '0) &&
                   (bus.cur_hr == r_alm_hr) && (bus.cur_min == r_alm_min);

  // Next-state, field, data register and registered-output computation.
  always_comb begin
    w_state_nxt      = r_state;
    w_fld_nxt        = r_fld;
    w_edit_hr_nxt    = r_edit_hr;
    w_edit_min_nxt   = r_edit_min;
    w_alm_hr_nxt     = r_alm_hr;
    w_alm_min_nxt    = r_alm_min;
    w_ring_cnt_nxt   = r_ring_cnt;
    w_time_load_nxt  = 1'b0;

    unique case (r_state)
      RUN: begin
        if (bus.btn_c) begin
          w_edit_hr_nxt  = bus.cur_hr;
          w_edit_min_nxt = bus.cur_min;
          w_fld_nxt      = F_THR;
          w_state_nxt    = ADJ;
        end else if (w_match) begin
          w_ring_cnt_nxt = '0;
          w_state_nxt    = RING;
        end
      end

      ADJ: begin
        if (bus.btn_c) begin
          w_time_load_nxt = 1'b1;
          w_state_nxt     = RUN;
        end else begin
          // Adjust uses the field selected before any move in this cycle.
          unique case (r_fld)
            F_THR:   w_edit_hr_nxt  = w_hr_next;
            F_TMIN:  w_edit_min_nxt = w_min_next;
            F_AHR:   w_alm_hr_nxt   = w_hr_next;
            F_AMIN:  w_alm_min_nxt  = w_min_next;
            default: ;
          endcase
          if (bus.btn_r && !bus.btn_l && (r_fld != F_AMIN)) begin
            w_fld_nxt = r_fld + 2'd1;
          end else if (bus.btn_l && !bus.btn_r && (r_fld != F_THR)) begin
            w_fld_nxt = r_fld - 2'd1;
          end
        end
      end

      RING: begin
        if (bus.tick_1hz) begin
          w_ring_cnt_nxt = r_ring_cnt + 8'd1;
        end
        if ((bus.tick_1hz && (r_ring_cnt == RING_LAST)) || bus.btn_c || !bus.alarm_en) begin
          w_ring_cnt_nxt = '0;
          w_state_nxt    = RUN;
        end
      end

      default: w_state_nxt = RUN;
    endcase

    w_adj_active_nxt = (w_state_nxt == ADJ);
    w_buzz_nxt       = (w_state_nxt == RING);
    w_mode_nxt       = (w_state_nxt == ADJ) ? fld_onehot(w_fld_nxt) : 4'b0000;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RUN;
      r_fld        <= F_THR;
      r_edit_hr    <= '0;
      r_edit_min   <= '0;
      r_alm_hr     <= '0;
      r_alm_min    <= '0;
      r_ring_cnt   <= '0;
      r_time_load  <= 1'b0;
      r_mode       <= '0;
      r_buzz       <= 1'b0;
      r_adj_active <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_fld        <= w_fld_nxt;
      r_edit_hr    <= w_edit_hr_nxt;
      r_edit_min   <= w_edit_min_nxt;
      r_alm_hr     <= w_alm_hr_nxt;
      r_alm_min    <= w_alm_min_nxt;
      r_ring_cnt   <= w_ring_cnt_nxt;
      r_time_load  <= w_time_load_nxt;
      r_mode       <= w_mode_nxt;
      r_buzz       <= w_buzz_nxt;
      r_adj_active <= w_adj_active_nxt;
    end
  end

  assign bus.mode       = r_mode;
  assign bus.edit_hr    = r_edit_hr;
  assign bus.edit_min   = r_edit_min;
  assign bus.time_load  = r_time_load;
  assign bus.alm_hr     = r_alm_hr;
  assign bus.alm_min    = r_alm_min;
  assign bus.buzz       = r_buzz;
  assign bus.adj_active = r_adj_active;

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// Bench for alarm_mode_ctrl: directed scenarios plus random stimulus vs a behavioural model.
module tb_alarm_mode_ctrl;

  localparam int RS = 60;

  logic clk = 1'b0;
  logic rst = 1'b0;

  alarm_mode_ctrl_if bus ();

  alarm_mode_ctrl #(.RING_SECS(RS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: mode flags, selected field, field values, ring counter.
  bit m_adj, m_ring, m_load;
  int m_fld, m_cnt;
  int m_v[4];   // 0 edit_hr, 1 edit_min, 2 alm_hr, 3 alm_min

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_adj = 0; m_ring = 0; m_load = 0; m_fld = 0; m_cnt = 0;
    for (int i = 0; i < 4; i++) m_v[i] = 0;
  endtask

  task automatic model_clock();
    bit c, l, r, u, d, t, en;
    int lim;
    c = bus.btn_c; l = bus.btn_l; r = bus.btn_r; u = bus.btn_u; d = bus.btn_d;
    t = bus.tick_1hz; en = bus.alarm_en;
    m_load = 0;
    if (m_ring) begin
      if (t) m_cnt++;
      if (m_cnt >= RS || c || !en) begin
        m_ring = 0;
        m_cnt  = 0;
      end
    end else if (m_adj) begin
      if (c) begin
        m_adj  = 0;
        m_load = 1;
      end else begin
        if (u != d) begin
          lim = (m_fld % 2 == 0) ? 24 : 60;
          m_v[m_fld] = (m_v[m_fld] + (u ? 1 : lim - 1)) % lim;
        end
        if (r && !l && m_fld < 3) m_fld++;
        if (l && !r && m_fld > 0) m_fld--;
      end
    end else begin
      if (c) begin
        m_adj = 1; m_fld = 0;
        m_v[0] = int'(bus.cur_hr);
        m_v[1] = int'(bus.cur_min);
      end else if (en && t && bus.cur_sec == 0 &&
                   int'(bus.cur_hr) == m_v[2] && int'(bus.cur_min) == m_v[3]) begin
        m_ring = 1;
        m_cnt  = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("mode",       int'(bus.mode),       m_adj ? (1 << m_fld) : 0);
    check("adj_active", int'(bus.adj_active), int'(m_adj));
    check("buzz",       int'(bus.buzz),       int'(m_ring));
    check("time_load",  int'(bus.time_load),  int'(m_load));
    check("edit_hr",    int'(bus.edit_hr),    m_v[0]);
    check("edit_min",   int'(bus.edit_min),   m_v[1]);
    check("alm_hr",     int'(bus.alm_hr),     m_v[2]);
    check("alm_min",    int'(bus.alm_min),    m_v[3]);
  endtask

  task automatic clear_pulses();
    bus.btn_c = 0; bus.btn_l = 0; bus.btn_r = 0; bus.btn_u = 0; bus.btn_d = 0;
    bus.tick_1hz = 0;
  endtask

  // One clock: DUT and model consume the same inputs, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    compare_all();
    clear_pulses();
  endtask

  // 0 c, 1 l, 2 r, 3 u, 4 d
  task automatic press(input int which, input int times);
    for (int k = 0; k < times; k++) begin
      case (which)
        0: bus.btn_c = 1;
        1: bus.btn_l = 1;
        2: bus.btn_r = 1;
        3: bus.btn_u = 1;
        default: bus.btn_d = 1;
      endcase
      step();
    end
  endtask

  task automatic set_cur(input int h, input int m, input int s);
    bus.cur_hr  = 5'(h);
    bus.cur_min = 6'(m);
    bus.cur_sec = 6'(s);
  endtask

  // Reset asserted between edges; its effect must be visible before the next edge.
  task automatic do_reset();
    #2 rst = 1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 0;
  endtask

  initial begin
    clear_pulses();
    bus.alarm_en = 0;
    set_cur(0, 0, 0);
    model_reset();
    @(negedge clk);
    do_reset();
    check("rst_mode", int'(bus.mode), 0);
    check("rst_buzz", int'(bus.buzz), 0);
    check("rst_alm_hr", int'(bus.alm_hr), 0);

    // Enter ADJ capturing current time.
    set_cur(7, 15, 20);
    press(0, 1);
    check("enter_adj", int'(bus.adj_active), 1);
    check("enter_mode", int'(bus.mode), 1);
    check("enter_edit_hr", int'(bus.edit_hr), 7);
    check("enter_edit_min", int'(bus.edit_min), 15);
    press(0, 1);
    check("exit_load_715", int'(bus.time_load), 1);

    // Wrap tests from 23:00.
    set_cur(23, 0, 5);
    press(0, 1);
    press(3, 1);
    check("hr_wrap_up", int'(bus.edit_hr), 0);
    press(2, 1);
    press(4, 1);
    check("min_wrap_down", int'(bus.edit_min), 59);
    press(0, 1);
    check("load_strobe", int'(bus.time_load), 1);
    check("load_adj_fall", int'(bus.adj_active), 0);
    check("load_mode0", int'(bus.mode), 0);
    check("load_hr", int'(bus.edit_hr), 0);
    check("load_min", int'(bus.edit_min), 59);
    step();
    check("load_single", int'(bus.time_load), 0);

    // Field saturation and simultaneous-button cancellation.
    set_cur(10, 20, 30);
    press(0, 1);
    press(2, 5);
    check("fld_sat_hi", int'(bus.mode), 8);
    press(1, 5);
    check("fld_sat_lo", int'(bus.mode), 1);
    bus.btn_l = 1; bus.btn_r = 1; step();
    check("lr_cancel", int'(bus.mode), 1);
    bus.btn_u = 1; bus.btn_d = 1; step();
    check("ud_cancel", int'(bus.edit_hr), 10);
    bus.btn_r = 1; bus.btn_u = 1; step();
    check("move_adj_old_fld_hr", int'(bus.edit_hr), 11);
    check("move_adj_mode", int'(bus.mode), 2);

    // Set alarm 06:30.
    press(2, 1);
    press(3, 6);
    press(2, 1);
    press(3, 30);
    check("alm_hr_set", int'(bus.alm_hr), 6);
    check("alm_min_set", int'(bus.alm_min), 30);
    press(0, 1);
    bus.alarm_en = 1;

    // Ring for RS ticks.
    set_cur(6, 30, 0); bus.tick_1hz = 1; step();
    check("ring_start", int'(bus.buzz), 1);
    for (int s = 1; s < RS; s++) begin
      set_cur(6, 30, s); bus.tick_1hz = 1; step();
      step();
    end
    check("ring_before_last", int'(bus.buzz), 1);
    set_cur(6, 31, 0); bus.tick_1hz = 1; step();
    check("ring_timeout", int'(bus.buzz), 0);

    // Dismiss with btn_c, no re-ring in same minute.
    set_cur(6, 30, 0); bus.tick_1hz = 1; step();
    check("ring2_start", int'(bus.buzz), 1);
    bus.btn_u = 1; step();
    check("ring_ignores_u", int'(bus.alm_hr), 6);
    press(0, 1);
    check("dismiss", int'(bus.buzz), 0);
    set_cur(6, 30, 1); bus.tick_1hz = 1; step();
    check("no_rering", int'(bus.buzz), 0);

    // btn_c wins over a match; matching suppressed in ADJ.
    set_cur(6, 30, 0); bus.tick_1hz = 1; bus.btn_c = 1; step();
    check("c_beats_match_adj", int'(bus.adj_active), 1);
    check("c_beats_match_buzz", int'(bus.buzz), 0);
    set_cur(6, 30, 0); bus.tick_1hz = 1; step();
    check("adj_suppress", int'(bus.buzz), 0);
    press(0, 1);

    // alarm_en low ends ringing.
    set_cur(6, 30, 0); bus.tick_1hz = 1; step();
    check("ring3_start", int'(bus.buzz), 1);
    step();
    bus.alarm_en = 0; step();
    check("en_low_exit", int'(bus.buzz), 0);
    bus.alarm_en = 1;

    // Ring again, then reset mid-RING; then reset mid-ADJ.
    set_cur(6, 30, 0); bus.tick_1hz = 1; step();
    do_reset();
    check("rst_ring_buzz", int'(bus.buzz), 0);
    set_cur(12, 34, 9);
    press(0, 1);
    press(3, 3);
    do_reset();
    check("rst_adj_load", int'(bus.time_load), 0);
    check("rst_adj_edit_hr", int'(bus.edit_hr), 0);
    check("rst_adj_active", int'(bus.adj_active), 0);
    step();
    check("rst_adj_no_load", int'(bus.time_load), 0);

    // Random phase, biased toward alarm matches.
    for (int n = 0; n < 4000; n++) begin
      bus.btn_c    = ($urandom_range(0, 7) == 0);
      bus.btn_l    = ($urandom_range(0, 4) == 0);
      bus.btn_r    = ($urandom_range(0, 4) == 0);
      bus.btn_u    = ($urandom_range(0, 3) == 0);
      bus.btn_d    = ($urandom_range(0, 3) == 0);
      bus.tick_1hz = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 40) == 0) bus.alarm_en = ~bus.alarm_en;
      if ($urandom_range(0, 1) == 0)
        set_cur(m_v[2], m_v[3], ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 59)));
      else
        set_cur(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), int'($urandom_range(0, 59)));
      if ($urandom_range(0, 600) == 0) begin
        clear_pulses();
        do_reset();
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alarm_mode_ctrl.md
# alarm_mode_ctrl

Mode controller for the digital alarm clock. It sequences clock adjustment and alarm setting from debounced button pulses, and owns the alarm hour/minute registers. It produces the one-hot field-select bus that drives the display/edit datapath and a one-cycle load strobe to the timekeeping counter. It also detects the alarm match and runs the ringing interval.

## Interface
- RING_SECS, 60: ringing duration in 1 Hz ticks before auto-stop (1..255)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn_c  in  1  single-cycle pulse; enter/exit adjust; dismiss ringing
- btn_l  in  1  single-cycle pulse; previous field
- btn_r  in  1  single-cycle pulse; next field
- btn_u  in  1  single-cycle pulse; increment field
- btn_d  in  1  single-cycle pulse; decrement field
- tick_1hz  in  1  single-cycle pulse once per second
- alarm_en  in  1  level; alarm armed
- cur_hr  in  5  current hour, 0..23
- cur_min  in  6  current minute, 0..59
- cur_sec  in  6  current second, 0..59
- mode  out  4  one-hot field select: 0001 time-hr, 0010 time-min, 0100 alarm-hr, 1000 alarm-min; 0000 outside ADJ
- edit_hr, edit_min  out  5/6  time values being edited; loaded value
- time_load  out  1  one-cycle strobe; timekeeper loads edit_hr/edit_min, clears seconds
- alm_hr, alm_min  out  5/6  stored alarm time
- buzz  out  1  high while ringing
- adj_active  out  1  high in ADJ

## Operation
- States: RUN, ADJ, RING. Field index `fld` is 0..3.
- RUN:
  - btn_c: copy cur_hr/cur_min to edit_hr/edit_min, set fld=0, go to ADJ.
  - Match: alarm_en and tick_1hz and cur_sec==0 and cur_hr==alm_hr and cur_min==alm_min go to RING, with ring count cleared.
  - If btn_c and a match occur in the same cycle, btn_c wins and the alarm is missed.
- ADJ:
  - btn_r: fld+1, saturating at 3.
  - btn_l: fld−1, saturating at 0. No wrap.
  - btn_l and btn_r in the same cycle: no change.
  - btn_u/btn_d: increment/decrement the selected field.
    - Fields map as 0 edit_hr, 1 edit_min, 2 alm_hr, 3 alm_min.
    - Hours wrap 23↔0; minutes wrap 59↔0.
    - btn_u and btn_d in the same cycle: no change.
  - Field move and adjust in the same cycle: the adjust applies to the old fld.
  - btn_c: time_load for one cycle, go to RUN. Alarm registers are already live.
  - Alarm matching is suppressed in ADJ.
- RING:
  - buzz=1. Each tick_1hz increments the ring count.
  - Return to RUN on any of: count reaching RING_SECS, btn_c, or alarm_en low.
  - btn_l, btn_r, btn_u and btn_d are ignored.
  - buzz=0 in the cycle after exit.
- Arithmetic: all adjusts are modular within field range, and registers never hold out-of-range values. Out-of-range cur_* values are undefined input.

## Timing
- All outputs are registered and update on the clk edge after the sampled pulse (1-cycle latency).
- Reset values:
  - Control: state RUN, fld 0, mode 0000, adj_active 0.
  - Registers: edit_hr 0, edit_min 0, alm_hr 0, alm_min 0.
  - Strobes and count: time_load 0, buzz 0, ring count 0.
- mode = one-hot(fld) when in ADJ, else 0000. It is valid from the cycle adj_active rises.
- time_load is high for exactly one cycle, coincident with adj_active falling. edit_hr/edit_min are stable on that cycle.
- Back-to-back pulses on consecutive cycles are each honoured.
- Reset asserted mid-ADJ discards edits and raises no time_load. Reset mid-RING stops buzz immediately (asynchronous).
- A match retriggers only at the next cur_sec==0 tick of a matching minute. Dismissing within the matching minute does not re-ring.

## Structure
- Package alarm_pkg holds:
  - the state enum (RUN, ADJ, RING)
  - field constants F_THR=0, F_TMIN=1, F_AHR=2, F_AMIN=3
  - HR_MAX=23, MIN_MAX=59
- One sub-module, mod_adj: combinational wrap increment/decrement, with value, max, up, down in and next value out. It is instantiated per field width.
- The FSM, field register, ring counter and data registers live in alarm_mode_ctrl.

## Test plan
- Reset, then btn_c with cur=07:15 → adj_active=1, mode=0001, edit=07:15.
- ADJ fld0 with edit_hr=23, btn_u → edit_hr=0. Then btn_r, btn_d with edit_min=0 → edit_min=59. Then btn_c → single time_load with 00:59, mode=0000.
- ADJ: btn_r ×5 → mode=1000 (saturates). btn_l ×5 → mode=0001. Simultaneous btn_l+btn_r or btn_u+btn_d → no change.
- Set alarm 06:30 via fields 2/3, alarm_en=1, drive cur 06:30:00 with tick_1hz → buzz=1 next cycle. After 60 ticks → buzz=0. btn_c during RING → buzz=0 next cycle.
- Matching time while in ADJ → no RING. alarm_en low during RING → exit. Async rst mid-ADJ → no time_load, all outputs at reset values.
